// File: rtl/reg_dump.sv
// ---------------------------------------------------------------------------
// reg_dump -- register-file dump sequencer
//
// On a Start pulse, walks the processor's debug read port from FIRST_REG to
// LAST_REG. Each register word is captured and streamed out on a valid/ready
// beat together with its index. The debug port is a registered read, so every
// address change is followed by one SETUP cycle before the data is captured.
//
// Optional feature (macro REG_DUMP_CHECKSUM_EN): an XOR checksum of all
// register beats is sent as one extra final beat with DumpIndex = 0. In that
// build, DumpLast is set only on the checksum beat.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   Start      in   begin a dump (sampled only while idle)
//   Busy       out  dump in progress
//   Done       out  one-cycle completion pulse
//   RegAddr    out  debug read address
//   RegData    in   debug read data (one cycle after RegAddr)
//   DumpValid  out  output beat valid
//   DumpReady  in   consumer accepts beat
//   DumpData   out  captured register word (or checksum)
//   DumpIndex  out  register index of the beat (0 for checksum)
//   DumpLast   out  final beat marker
// ---------------------------------------------------------------------------
module reg_dump #(
    parameter int FIRST_REG  = 1,
    parameter int LAST_REG   = 31,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    output logic                  Busy,
    output logic                  Done,
    output logic [ADDR_WIDTH-1:0] RegAddr,
    input  logic [DATA_WIDTH-1:0] RegData,
    output logic                  DumpValid,
    input  logic                  DumpReady,
    output logic [DATA_WIDTH-1:0] DumpData,
    output logic [ADDR_WIDTH-1:0] DumpIndex,
    output logic                  DumpLast
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_OUTPUT  = 3'd3;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam logic [2:0] ST_CHECK   = 3'd4;
`endif

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LAST_REG);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    logic [2:0] state;
    logic       at_last;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;
`endif

    assign at_last = (RegAddr == LAST_ADDR);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            RegAddr   <= '0;
            DumpValid <= 1'b0;
            DumpData  <= '0;
            DumpIndex <= '0;
            DumpLast  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            // Done is a single-cycle pulse; it is only raised on the
            // completing handshake below.
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        RegAddr <= FIRST_ADDR;
                        Busy    <= 1'b1;
                        state   <= ST_SETUP;
`ifdef REG_DUMP_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end

                // Registered read port: RegData reflects RegAddr one cycle
                // after it changes, so wait here once per register.
                ST_SETUP: begin
                    state <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    DumpData  <= RegData;
                    DumpIndex <= RegAddr;
                    DumpValid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    DumpLast  <= 1'b0;
`else
                    DumpLast  <= at_last;
`endif
                    state     <= ST_OUTPUT;
                end

                // DumpValid is always high in this state, so DumpReady alone
                // marks the handshake. Outputs stay untouched until then.
                ST_OUTPUT: begin
                    if (DumpReady) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        checksum <= checksum ^ DumpData;
`endif
                        if (!at_last) begin
                            DumpValid <= 1'b0;
                            RegAddr   <= RegAddr + ADDR_ONE;
                            state     <= ST_SETUP;
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // Load the checksum beat straight away, folding
                            // in the beat being accepted on this edge. Valid
                            // stays high, so the new beat follows back-to-back.
                            DumpData  <= checksum ^ DumpData;
                            DumpIndex <= '0;
                            DumpLast  <= 1'b1;
                            state     <= ST_CHECK;
`else
                            DumpValid <= 1'b0;
                            Busy      <= 1'b0;
                            Done      <= 1'b1;
                            state     <= ST_IDLE;
`endif
                        end
                    end
                end

`ifdef REG_DUMP_CHECKSUM_EN
                ST_CHECK: begin
                    if (DumpReady) begin
                        DumpValid <= 1'b0;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// ---------------------------------------------------------------------------
// tb_reg_dump -- scoreboard bench for reg_dump
//
// A register-file model with a registered read port drives two DUTs: the
// default configuration (registers 1..31), and a FIRST_REG = LAST_REG = 4
// instance. Each dump pushes its expected beats, derived from the register
// contents, into a queue. Negedge monitors pop the queue on every handshake
// and compare. While a beat is stalled, the monitors also check that it
// holds steady. Follows REG_DUMP_CHECKSUM_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_reg_dump;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic reset;
    // DUT 1 (defaults)
    logic          start, busy, done, dump_valid, dump_ready, dump_last;
    logic [AW-1:0] reg_addr, dump_index;
    logic [DW-1:0] reg_data, dump_data;
    // DUT 2 (single register 4)
    logic          start2, busy2, done2, dump_valid2, dump_ready2, dump_last2;
    logic [AW-1:0] reg_addr2, dump_index2;
    logic [DW-1:0] reg_data2, dump_data2;

    logic [DW-1:0] regs [0:31];
    always @(posedge clk) begin
        reg_data  <= regs[reg_addr];
        reg_data2 <= regs[reg_addr2];
    end

    reg_dump dut (
        .Clock(clk), .Reset(reset), .Start(start), .Busy(busy), .Done(done),
        .RegAddr(reg_addr), .RegData(reg_data), .DumpValid(dump_valid),
        .DumpReady(dump_ready), .DumpData(dump_data), .DumpIndex(dump_index),
        .DumpLast(dump_last)
    );

    reg_dump #(.FIRST_REG(4), .LAST_REG(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut2 (
        .Clock(clk), .Reset(reset), .Start(start2), .Busy(busy2), .Done(done2),
        .RegAddr(reg_addr2), .RegData(reg_data2), .DumpValid(dump_valid2),
        .DumpReady(dump_ready2), .DumpData(dump_data2), .DumpIndex(dump_index2),
        .DumpLast(dump_last2)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    beat_t exp1[$];
    beat_t exp2[$];

    // Reference model: one beat per register in order, then the XOR
    // checksum beat when that feature is built in.
    task automatic expect_dump(input int which, input int first, input int last);
        beat_t         b;
        logic [DW-1:0] sum;
        sum = '0;
        for (int i = first; i <= last; i++) begin
            b.data = regs[i];
            b.idx  = AW'(i);
            b.last = (XTRA == 0) && (i == last);
            sum    = sum ^ regs[i];
            if (which == 1) exp1.push_back(b);
            else            exp2.push_back(b);
        end
        if (XTRA == 1) begin
            b.data = sum;
            b.idx  = '0;
            b.last = 1'b1;
            if (which == 1) exp1.push_back(b);
            else            exp2.push_back(b);
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 32; i++) regs[i] = 32'hA5A5_0000 | 32'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
    endtask

    // ---------------- monitors ----------------
    logic  stall1 = 1'b0;
    beat_t held1;
    int    beats1 = 0, done_cnt1 = 0, done_cyc1 = 0;

    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            stall1 <= 1'b0;
        end else begin
            if (stall1) begin
                chk("stall_valid", dump_valid, 1);
                chk("stall_hold", {dump_data, dump_index, dump_last}, held1);
            end
            if (dump_valid && dump_ready) begin
                beats1 <= beats1 + 1;
                if (exp1.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got index %0d, required no beat", dump_index);
                end else begin
                    b = exp1.pop_front();
                    chk("beat_data", dump_data, b.data);
                    chk("beat_index", dump_index, b.idx);
                    chk("beat_last", dump_last, b.last);
                end
            end
            stall1 <= dump_valid && !dump_ready;
            held1  <= {dump_data, dump_index, dump_last};
            if (done) begin
                done_cnt1 <= done_cnt1 + 1;
                done_cyc1 <= cyc;
                chk("done_not_busy", busy, 0);
            end
        end
    end

    int beats2 = 0, done_cnt2 = 0, done_cyc2 = 0;

    always @(negedge clk) begin
        beat_t b;
        if (!reset) begin
            if (dump_valid2 && dump_ready2) begin
                beats2 <= beats2 + 1;
                if (exp2.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat2: got index %0d, required no beat", dump_index2);
                end else begin
                    b = exp2.pop_front();
                    chk("beat2_data", dump_data2, b.data);
                    chk("beat2_index", dump_index2, b.idx);
                    chk("beat2_last", dump_last2, b.last);
                end
            end
            if (done2) begin
                done_cnt2 <= done_cnt2 + 1;
                done_cyc2 <= cyc;
                chk("done2_not_busy", busy2, 0);
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic start1(output int k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = cyc;
        chk("start_busy", busy, 1);
        chk("start_addr", reg_addr, 1);
    endtask

    task automatic wait_done1(input int target);
        int n = 0;
        while (done_cnt1 < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_cnt1 < target) begin
            checks++;
            $display("FAIL done_timeout: got %0d done pulses, required %0d", done_cnt1, target);
        end
    endtask

    task automatic wait_beat(input int idx);
        int n = 0;
        while (!(dump_valid && dump_index == AW'(idx)) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            $display("FAIL wait_beat: got no beat %0d, required one within 300 cycles", idx);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, d0, b0;
        reset = 1'b1; start = 1'b0; dump_ready = 1'b1;
        start2 = 1'b0; dump_ready2 = 1'b1;
        fill_pattern();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", dump_valid, 0);
        chk("rst_data", dump_data, 0);
        chk("rst_index", dump_index, 0);
        chk("rst_last", dump_last, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_valid2", dump_valid2, 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_valid", dump_valid, 0);
        chk("idle_done_cnt", done_cnt1, 0);

        // full dump, ready held high
        d0 = done_cnt1; b0 = beats1;
        expect_dump(1, 1, 31);
        start1(k);
        wait_done1(d0 + 1);
        chk("full_done_cycle", done_cyc1, k + 93 + XTRA);
        chk("full_beats", beats1 - b0, 31 + XTRA);
        chk("full_queue", exp1.size(), 0);
        chk("full_busy_after", busy, 0);

        // backpressure: ready low for 5 cycles while beat 7 is valid
        repeat (2) @(posedge clk);
        #1;
        d0 = done_cnt1; b0 = beats1;
        expect_dump(1, 1, 31);
        start1(k);
        wait_beat(7);
        dump_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dump_ready = 1'b1;
        wait_done1(d0 + 1);
        chk("bp_done_cycle", done_cyc1, k + 93 + 5 + XTRA);
        chk("bp_beats", beats1 - b0, 31 + XTRA);
        chk("bp_queue", exp1.size(), 0);

        // Start while busy is ignored
        repeat (2) @(posedge clk);
        #1;
        d0 = done_cnt1; b0 = beats1;
        expect_dump(1, 1, 31);
        start1(k);
        wait_beat(3);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_beat(20);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_done1(d0 + 1);
        chk("sb_done_cycle", done_cyc1, k + 93 + XTRA);
        repeat (10) @(posedge clk);
        #1;
        chk("sb_done_cnt", done_cnt1 - d0, 1);
        chk("sb_beats", beats1 - b0, 31 + XTRA);
        chk("sb_busy", busy, 0);

        // reset while beat 10 is valid and unaccepted
        d0 = done_cnt1;
        expect_dump(1, 1, 31);
        start1(k);
        wait_beat(10);
        dump_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", dump_valid, 0);
        chk("mid_rst_busy", busy, 0);
        exp1.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        dump_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt1 - d0, 0);
        d0 = done_cnt1; b0 = beats1;
        expect_dump(1, 1, 31);
        start1(k);
        wait_done1(d0 + 1);
        chk("post_rst_done_cycle", done_cyc1, k + 93 + XTRA);
        chk("post_rst_beats", beats1 - b0, 31 + XTRA);

        // randomized register contents and random backpressure
        for (int r = 0; r < 3; r++) begin
            int n;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            fill_random();
            d0 = done_cnt1; b0 = beats1;
            expect_dump(1, 1, 31);
            start1(k);
            n = 0;
            while (done_cnt1 == d0 && n < 2000) begin
                @(posedge clk); #1;
                dump_ready = ($urandom_range(0, 3) != 0);
                n++;
            end
            dump_ready = 1'b1;
            wait_done1(d0 + 1);
            chk("rnd_beats", beats1 - b0, 31 + XTRA);
            chk("rnd_queue", exp1.size(), 0);
        end

        // single-register instance
        for (int r = 0; r < 2; r++) begin
            if (r == 0) fill_pattern();
            else        fill_random();
            d0 = done_cnt2; b0 = beats2;
            expect_dump(2, 4, 4);
            start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            k = cyc;
            chk("p2_busy", busy2, 1);
            chk("p2_addr", reg_addr2, 4);
            repeat (8) @(posedge clk);
            #1;
            chk("p2_done_cnt", done_cnt2 - d0, 1);
            chk("p2_done_cycle", done_cyc2, k + 3 + XTRA);
            chk("p2_beats", beats2 - b0, 1 + XTRA);
            chk("p2_queue", exp2.size(), 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
